mux_rr_sel_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 8:1 bit mux between 8 requesters.

---
 rtl/mux_rr_sel_arbiter.sv | 108 ++++++++++
 tb/tb_mux_rr_sel_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter sharing one N:1 mux select between N requesters.
// Grants one owner at a time and force-releases it after MAX_HOLD cycles.
module mux_rr_sel_arbiter #(
   parameter int N        = 8,
   parameter int SEL_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             timeout
);

   localparam int                 HOLD_W    = 8;
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
   localparam logic [N-1:0]       GRANT_ONE = N'(1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [N-1:0]        grant_d;
   logic [SEL_W-1:0]    sel_d;
   logic                busy_d, timeout_d;

   logic                found;
   logic [SEL_W-1:0]    pick, idx;
   logic                rel_done, rel_drop, rel_hold;

   // Scan from ptr upward; SEL_W-bit addition wraps mod N since N is a power of two.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = ptr_q;
      for (int i = 0; i < N; i++) begin
         idx = ptr_q + SEL_W'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign rel_done = done;
   assign rel_drop = !req[sel];
   assign rel_hold = (hold_q == HOLD_LAST);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant;
      sel_d     = sel;
      busy_d    = busy;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               grant_d = GRANT_ONE << pick;
               sel_d   = pick;
               busy_d  = 1'b1;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_hold) begin
               state_d   = IDLE;
               grant_d   = '0;
               busy_d    = 1'b0;
               ptr_d     = sel + SEL_ONE;
               // Only a pure hold-limit release counts as a forced timeout.
               timeout_d = rel_hold && !rel_done && !rel_drop;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant   <= '0;
         sel     <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant   <= grant_d;
         sel     <= sel_d;
         busy    <= busy_d;
         timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Bench for mux_rr_sel_arbiter: directed scenarios plus random traffic,
// all outputs compared against a transaction-level owner/pointer model.
module tb_mux_rr_sel_arbiter;

   localparam int N        = 8;
   localparam int SEL_W    = 3;
   localparam int MAX_HOLD = 16;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic             done;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             timeout;

   int n_checks = 0;
   int n_fail   = 0;
   bit inv_on   = 0;

   // reference model: who owns the mux, how long it has held it, next start index
   int m_owner;
   int m_held;
   int m_ptr;
   int m_sel;
   bit m_timeout;

   mux_rr_sel_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_held    = 0;
      m_ptr     = 0;
      m_sel     = 0;
      m_timeout = 0;
   endtask

   // advance the model by one clock using the inputs present at the edge
   task automatic model_edge(input logic [N-1:0] r, input logic d);
      int k;
      m_timeout = 0;
      if (m_owner < 0) begin
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (m_owner < 0 && r[k]) begin
               m_owner = k;
               m_sel   = k;
               m_held  = 1;
            end
         end
      end else begin
         k = m_owner;
         if (d || !r[k] || m_held >= MAX_HOLD) begin
            m_timeout = (m_held >= MAX_HOLD) && !d && r[k];
            m_ptr     = (k + 1) % N;
            m_owner   = -1;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic compare_model();
      logic [N-1:0] exp_grant;
      exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("grant", grant, exp_grant);
      check("sel", sel, m_sel);
      check("busy", busy, m_owner >= 0);
      check("timeout", timeout, m_timeout);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(req, done);
      #1;
      compare_model();
   endtask

   task automatic async_reset_pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_grant", grant, 0);
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (inv_on && rst_n) begin
         check("inv_onehot", $onehot0(grant), 1);
         check("inv_busy", busy, |grant);
         check("inv_sel", busy ? grant[sel] : 1'b1, 1);
         check("inv_timeout", timeout && busy, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_grant", grant, 0);
      check("reset_sel", sel, 0);
      check("reset_busy", busy, 0);
      rst_n  = 1'b1;
      inv_on = 1;

      // reset in the middle of a grant, then restart from index 0
      req = 8'h01;
      step();
      check("pre_rst_busy", busy, 1);
      #2;
      async_reset_pulse();
      req = 8'h80;
      step();
      check("post_rst_grant", grant, 8'h80);
      check("post_rst_sel", sel, 7);

      // release owner 7 by dropping its request, ptr -> 0
      req = 8'h00;
      step();
      step();

      // round robin with everyone requesting
      req = 8'hFF;
      step();
      for (int i = 0; i < 9; i++) begin
         check("rr_sel", sel, i % N);
         check("rr_busy", busy, 1);
         done = 1'b1;
         step();
         done = 1'b0;
         check("rr_bubble", busy, 0);
         step();
      end
      req = 8'h00;
      step();
      step();

      // wrap: owner 6, then 0 and 6 both request
      req = 8'h40;
      step();
      check("wrap_own6", sel, 6);
      req  = 8'h41;
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      check("wrap_sel0", sel, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      check("wrap_sel6", sel, 6);
      req = 8'h00;
      step();
      step();

      // hold-limit timeout
      req = 8'h04;
      step();
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         step();
      end
      check("hold_cycles", cnt, MAX_HOLD);
      check("hold_timeout", timeout, 1);
      step();
      check("hold_to_clear", timeout, 0);
      check("hold_regrant", sel, 2);
      check("hold_regrant_busy", busy, 1);

      // owner drop and combined done+drop
      req = 8'h08;
      step();
      step();
      check("drop_own3", sel, 3);
      req = 8'h00;
      step();
      check("drop_grant", grant, 0);
      check("drop_timeout", timeout, 0);
      req = 8'h08;
      step();
      check("drop2_own3", grant, 8'h08);
      req  = 8'h00;
      done = 1'b1;
      step();
      done = 1'b0;
      check("both_grant", grant, 0);
      check("both_timeout", timeout, 0);
      step();

      // random traffic with mostly stable requests and occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         else if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N-1)] = ~req[$urandom_range(0, N-1)];
         done = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #1;
            async_reset_pulse();
         end
         step();
      end

      req  = '0;
      done = 1'b0;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
